// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch flush, I/D-miss, halt drain.
// Controls are combinational from state and inputs; state and counters update on clk.
module pipe_hazard_ctrl #(
   parameter int STALL_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         ID_Rs,
   input  logic [3:0]         ID_Rt,
   input  logic               ID_rsValid,
   input  logic               ID_rtValid,
   input  logic               ID_hlt,
   input  logic               EX_memRead,
   input  logic [3:0]         EX_Rd,
   input  logic               brTaken,
   input  logic               iMiss,
   input  logic               iReady,
   input  logic               dMiss,
   input  logic               dReady,
   output logic               pcWe,
   output logic               IF_ID_we,
   output logic               IF_ID_CLR,
   output logic               ID_EX_we,
   output logic               ID_EX_CLR,
   output logic               EX_MEM_we,
   output logic               MEM_WB_we,
   output logic               halted,
   output logic [STALL_W-1:0] stallCycles
);

   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_IWAIT = 2'd1;
   localparam logic [1:0] S_DWAIT = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   logic [1:0] state, state_nxt;
   logic [1:0] ret_state, ret_nxt;
   logic [1:0] drain_cnt, drain_nxt;
   logic       halt_entry;
   logic       load_use;
   logic       pc_we_c, if_id_we_c, if_id_clr_c, id_ex_we_c, id_ex_clr_c, ex_mem_we_c, mem_wb_we_c;

   assign load_use = EX_memRead && (EX_Rd != 4'd0) &&
                     ((ID_rsValid && (ID_Rs == EX_Rd)) || (ID_rtValid && (ID_Rt == EX_Rd)));

   always_comb begin
      pc_we_c     = 1'b1;
      if_id_we_c  = 1'b1;
      if_id_clr_c = 1'b0;
      id_ex_we_c  = 1'b1;
      id_ex_clr_c = 1'b0;
      ex_mem_we_c = 1'b1;
      mem_wb_we_c = 1'b1;
      state_nxt   = state;
      ret_nxt     = ret_state;
      drain_nxt   = drain_cnt;
      halt_entry  = 1'b0;
      case (state)
         S_RUN: begin
            if (dMiss) begin
               {pc_we_c, if_id_we_c, id_ex_we_c, ex_mem_we_c, mem_wb_we_c} = 5'b0;
               state_nxt = S_DWAIT;
               ret_nxt   = iMiss ? S_IWAIT : S_RUN;
            end else if (brTaken) begin
               if_id_clr_c = 1'b1;
               id_ex_clr_c = 1'b1;
            end else if (ID_hlt) begin
               pc_we_c    = 1'b0;
               if_id_we_c = 1'b0;
               state_nxt  = S_HALT;
               drain_nxt  = 2'd0;
               halt_entry = 1'b1;
            end else if (load_use || iMiss) begin
               pc_we_c     = 1'b0;
               if_id_we_c  = 1'b0;
               id_ex_clr_c = 1'b1;
               if (!load_use) state_nxt = S_IWAIT;
            end
         end
         S_IWAIT: begin
            if (dMiss) begin
               {pc_we_c, if_id_we_c, id_ex_we_c, ex_mem_we_c, mem_wb_we_c} = 5'b0;
               state_nxt = S_DWAIT;
               ret_nxt   = S_IWAIT;
            end else if (brTaken) begin
               // pcWe=1 here doubles as the I-cache abort
               if_id_clr_c = 1'b1;
               id_ex_clr_c = 1'b1;
               state_nxt   = S_RUN;
            end else if (iReady) begin
               state_nxt = S_RUN;
               if (load_use) begin
                  pc_we_c     = 1'b0;
                  if_id_we_c  = 1'b0;
                  id_ex_clr_c = 1'b1;
               end
            end else begin
               pc_we_c     = 1'b0;
               if_id_we_c  = 1'b0;
               id_ex_clr_c = 1'b1;
            end
         end
         S_DWAIT: begin
            {pc_we_c, if_id_we_c, id_ex_we_c, ex_mem_we_c, mem_wb_we_c} = 5'b0;
            if (iReady && (ret_state == S_IWAIT)) ret_nxt = S_RUN;
            if (dReady) state_nxt = ret_nxt;
         end
         default: begin
            if (dMiss) begin
               {pc_we_c, if_id_we_c, id_ex_we_c, ex_mem_we_c, mem_wb_we_c} = 5'b0;
               state_nxt = S_DWAIT;
               ret_nxt   = S_HALT;
            end else begin
               pc_we_c     = 1'b0;
               if_id_we_c  = 1'b0;
               id_ex_clr_c = 1'b1;
               drain_nxt   = (drain_cnt == 2'd3) ? 2'd3 : drain_cnt + 2'd1;
            end
         end
      endcase
   end

   assign pcWe      = rst_n & pc_we_c;
   assign IF_ID_we  = rst_n & if_id_we_c;
   assign IF_ID_CLR = rst_n & if_id_clr_c;
   assign ID_EX_we  = rst_n & id_ex_we_c;
   assign ID_EX_CLR = rst_n & id_ex_clr_c;
   assign EX_MEM_we = rst_n & ex_mem_we_c;
   assign MEM_WB_we = rst_n & mem_wb_we_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_RUN;
         ret_state   <= S_RUN;
         drain_cnt   <= 2'd0;
         halted      <= 1'b0;
         stallCycles <= '0;
      end else begin
         state     <= state_nxt;
         ret_state <= ret_nxt;
         drain_cnt <= drain_nxt;
         halted    <= (drain_nxt == 2'd3);
         // Only front-end stalls count; halt drain is not a stall
         if (!pc_we_c && (state != S_HALT) && !halt_entry && (stallCycles != '1))
            stallCycles <= stallCycles + {{(STALL_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  ID_Rs, ID_Rt, EX_Rd;
   logic        ID_rsValid, ID_rtValid, ID_hlt, EX_memRead, brTaken, iMiss, iReady, dMiss, dReady;
   logic        pcWe, IF_ID_we, IF_ID_CLR, ID_EX_we, ID_EX_CLR, EX_MEM_we, MEM_WB_we, halted;
   logic [15:0] stallCycles;
   logic [6:0]  ctl;

   int total = 0;
   int bad   = 0;

   // {pcWe, IF_ID_we, IF_ID_CLR, ID_EX_we, ID_EX_CLR, EX_MEM_we, MEM_WB_we}
   localparam logic [6:0] C_DEF   = 7'b1101011;
   localparam logic [6:0] C_FRZ   = 7'b0000000;
   localparam logic [6:0] C_FRONT = 7'b0001111;
   localparam logic [6:0] C_FLUSH = 7'b1111111;
   localparam logic [6:0] C_HENT  = 7'b0001011;

   assign ctl = {pcWe, IF_ID_we, IF_ID_CLR, ID_EX_we, ID_EX_CLR, EX_MEM_we, MEM_WB_we};

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.STALL_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_rsValid(ID_rsValid),
      .ID_rtValid(ID_rtValid), .ID_hlt(ID_hlt), .EX_memRead(EX_memRead), .EX_Rd(EX_Rd),
      .brTaken(brTaken), .iMiss(iMiss), .iReady(iReady), .dMiss(dMiss), .dReady(dReady),
      .pcWe(pcWe), .IF_ID_we(IF_ID_we), .IF_ID_CLR(IF_ID_CLR), .ID_EX_we(ID_EX_we),
      .ID_EX_CLR(ID_EX_CLR), .EX_MEM_we(EX_MEM_we), .MEM_WB_we(MEM_WB_we),
      .halted(halted), .stallCycles(stallCycles)
   );

   task automatic idle();
      ID_Rs = 4'd0; ID_Rt = 4'd0; ID_rsValid = 1'b0; ID_rtValid = 1'b0; ID_hlt = 1'b0;
      EX_memRead = 1'b0; EX_Rd = 4'd0; brTaken = 1'b0;
      iMiss = 1'b0; iReady = 1'b0; dMiss = 1'b0; dReady = 1'b0;
   endtask

   // Advance to just after the next rising edge, then let comb outputs settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      #2;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         {ID_Rs, ID_Rt, EX_Rd} = 12'($urandom);
         {ID_rsValid, ID_rtValid, ID_hlt, EX_memRead, brTaken, iMiss, iReady, dMiss, dReady} = 9'($urandom);
         #2;
         total++;
         if (ctl !== C_FRZ) begin bad++; $display("FAIL reset_ctl got=%b want=%b", ctl, C_FRZ); end
         total++;
         if (stallCycles !== 16'd0 || halted !== 1'b0) begin
            bad++; $display("FAIL reset_state got stall=%0d halted=%b want 0/0", stallCycles, halted);
         end
         step();
      end
      idle();
      rst_n = 1'b1;
      #2;
      total++;
      if (ctl !== C_DEF) begin bad++; $display("FAIL release_ctl got=%b want=%b", ctl, C_DEF); end
      step();
      total++;
      if (ctl !== C_DEF) begin bad++; $display("FAIL idle_ctl got=%b want=%b", ctl, C_DEF); end
   endtask

   task automatic test_load_use();
      do_reset();
      EX_memRead = 1'b1; EX_Rd = 4'd5; ID_Rs = 4'd5; ID_rsValid = 1'b1;
      #2;
      total++;
      if (ctl !== C_FRONT) begin bad++; $display("FAIL lu_rs_ctl got=%b want=%b", ctl, C_FRONT); end
      step();
      idle();
      #2;
      total++;
      if (ctl !== C_DEF) begin bad++; $display("FAIL lu_after_ctl got=%b want=%b", ctl, C_DEF); end
      total++;
      if (stallCycles !== 16'd1) begin bad++; $display("FAIL lu_stall got=%0d want=1", stallCycles); end
      // Rd=0 never creates a hazard
      EX_memRead = 1'b1; EX_Rd = 4'd0; ID_Rs = 4'd0; ID_rsValid = 1'b1;
      #2;
      total++;
      if (ctl !== C_DEF) begin bad++; $display("FAIL lu_r0_ctl got=%b want=%b", ctl, C_DEF); end
      step();
      // Rt match only counts when rtValid
      EX_memRead = 1'b1; EX_Rd = 4'd7; ID_Rt = 4'd7; ID_rtValid = 1'b0; ID_rsValid = 1'b0;
      #2;
      total++;
      if (ctl !== C_DEF) begin bad++; $display("FAIL lu_rtinv_ctl got=%b want=%b", ctl, C_DEF); end
      step();
      ID_rtValid = 1'b1;
      #2;
      total++;
      if (ctl !== C_FRONT) begin bad++; $display("FAIL lu_rt_ctl got=%b want=%b", ctl, C_FRONT); end
      step();
      idle();
      #2;
      total++;
      if (stallCycles !== 16'd2) begin bad++; $display("FAIL lu_stall2 got=%0d want=2", stallCycles); end
   endtask

   task automatic test_dmiss();
      logic [6:0] exp;
      do_reset();
      for (int c = 0; c < 7; c++) begin
         idle();
         dMiss   = (c == 1);
         dReady  = (c == 4);
         brTaken = (c >= 2 && c <= 4);
         exp = (c >= 1 && c <= 4) ? C_FRZ : C_DEF;
         #2;
         total++;
         if (ctl !== exp) begin bad++; $display("FAIL dmiss_c%0d got=%b want=%b", c, ctl, exp); end
         step();
      end
      total++;
      if (stallCycles !== 16'd4) begin bad++; $display("FAIL dmiss_stall got=%0d want=4", stallCycles); end
   endtask

   task automatic test_imiss_dmiss();
      logic [6:0] exp;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         idle();
         iMiss  = (c == 0);
         dMiss  = (c == 0);
         iReady = (c == 1);
         dReady = (c == 3);
         exp = (c <= 3) ? C_FRZ : C_DEF;
         #2;
         total++;
         if (ctl !== exp) begin bad++; $display("FAIL idmiss_c%0d got=%b want=%b", c, ctl, exp); end
         step();
      end
      total++;
      if (stallCycles !== 16'd4) begin bad++; $display("FAIL idmiss_stall got=%0d want=4", stallCycles); end
   endtask

   task automatic test_imiss_branch();
      logic [6:0] exp;
      do_reset();
      for (int c = 0; c < 7; c++) begin
         idle();
         iMiss   = (c == 0 || c == 4);
         brTaken = (c == 2);
         iReady  = (c == 5);
         case (c)
            0, 1, 4: exp = C_FRONT;
            2:       exp = C_FLUSH;
            default: exp = C_DEF;
         endcase
         #2;
         total++;
         if (ctl !== exp) begin bad++; $display("FAIL ibr_c%0d got=%b want=%b", c, ctl, exp); end
         step();
      end
      total++;
      if (stallCycles !== 16'd3) begin bad++; $display("FAIL ibr_stall got=%0d want=3", stallCycles); end
   endtask

   task automatic test_halt();
      logic [6:0] exp;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         idle();
         ID_hlt  = (c == 0);
         brTaken = (c == 2);
         iMiss   = (c == 3);
         exp = (c == 0) ? C_HENT : C_FRONT;
         #2;
         total++;
         if (ctl !== exp) begin bad++; $display("FAIL halt_c%0d got=%b want=%b", c, ctl, exp); end
         total++;
         if (halted !== (c >= 4)) begin bad++; $display("FAIL halted_c%0d got=%b want=%b", c, halted, c >= 4); end
         step();
      end
      total++;
      if (stallCycles !== 16'd0) begin bad++; $display("FAIL halt_stall got=%0d want=0", stallCycles); end
   endtask

   task automatic test_halt_dmiss();
      logic [6:0] exp;
      do_reset();
      for (int c = 0; c < 9; c++) begin
         idle();
         ID_hlt = (c == 0);
         dMiss  = (c == 2);
         dReady = (c == 4);
         case (c)
            0:       exp = C_HENT;
            2, 3, 4: exp = C_FRZ;
            default: exp = C_FRONT;
         endcase
         #2;
         total++;
         if (ctl !== exp) begin bad++; $display("FAIL hdm_c%0d got=%b want=%b", c, ctl, exp); end
         total++;
         if (halted !== (c >= 7)) begin bad++; $display("FAIL hdm_halted_c%0d got=%b want=%b", c, halted, c >= 7); end
         step();
      end
      total++;
      if (stallCycles !== 16'd2) begin bad++; $display("FAIL hdm_stall got=%0d want=2", stallCycles); end
   endtask

   task automatic test_halt_branch();
      logic [6:0] exp;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         idle();
         ID_hlt  = (c == 0);
         brTaken = (c == 0);
         exp = (c == 0) ? C_FLUSH : C_DEF;
         #2;
         total++;
         if (ctl !== exp) begin bad++; $display("FAIL hbr_c%0d got=%b want=%b", c, ctl, exp); end
         step();
      end
      total++;
      if (halted !== 1'b0) begin bad++; $display("FAIL hbr_halted got=%b want=0", halted); end
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      #1;
      test_reset();
      test_load_use();
      test_dmiss();
      test_imiss_dmiss();
      test_imiss_branch();
      test_halt();
      test_halt_dmiss();
      test_halt_branch();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
